mem_arbiter: RTL and testbench

- Shares the single memory accessor between two requesters: port 0 is CPU instruction fetch (read-only), port 1 is CPU data load/store (read or write).
- Serialises requests, drives the memory read/write handshake and returns a one-cycle acknowledge with read data to the granted requester.
- Round-robin arbitration between the two ports, plus a watchdog that terminates a transaction the memory never answers.
- Sits between the cpu core and the memory model.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory accessor: port 0 is instruction
// fetch (read-only), port 1 is data load/store. A watchdog aborts accesses memory never answers.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_read_value,
    input  logic              mem_read_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_value,
    input  logic              mem_write_ready,

    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StAck} state_e;

    localparam logic [15:0] WdLast = 16'(TIMEOUT - 1);

    state_e            state_q;
    logic              gnt_q;
    logic              last_grant_q;
    logic              err_q;
    logic [15:0]       wdog_q;
    logic [DATA_W-1:0] data_q;
    logic              pick_p0;

    // Port 0 wins when alone, or under contention when port 1 was granted last.
    assign pick_p0 = p0_req && (!p1_req || last_grant_q);
    assign busy    = (state_q != StIdle);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= StIdle;
            gnt_q             <= 1'b0;
            last_grant_q      <= 1'b1;
            err_q             <= 1'b0;
            wdog_q            <= '0;
            data_q            <= '0;
            p0_ack            <= 1'b0;
            p0_rdata          <= '0;
            p0_err            <= 1'b0;
            p1_ack            <= 1'b0;
            p1_rdata          <= '0;
            p1_err            <= 1'b0;
            mem_read          <= 1'b0;
            mem_read_address  <= '0;
            mem_write         <= 1'b0;
            mem_write_address <= '0;
            mem_write_value   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (p0_req || p1_req) begin
                        gnt_q        <= !pick_p0;
                        last_grant_q <= !pick_p0;
                        wdog_q       <= '0;
                        if (pick_p0) begin
                            mem_read         <= 1'b1;
                            mem_read_address <= p0_addr;
                            state_q          <= StRd;
                        end else if (p1_we) begin
                            mem_write         <= 1'b1;
                            mem_write_address <= p1_addr;
                            mem_write_value   <= p1_wdata;
                            state_q           <= StWr;
                        end else begin
                            mem_read         <= 1'b1;
                            mem_read_address <= p1_addr;
                            state_q          <= StRd;
                        end
                    end
                end
                StRd: begin
                    // Ready on the expiry cycle still counts as a successful read.
                    if (mem_read_ready) begin
                        data_q   <= mem_read_value;
                        err_q    <= 1'b0;
                        mem_read <= 1'b0;
                        state_q  <= StAck;
                    end else if (wdog_q == WdLast) begin
                        data_q   <= '0;
                        err_q    <= 1'b1;
                        mem_read <= 1'b0;
                        state_q  <= StAck;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                StWr: begin
                    if (mem_write_ready) begin
                        err_q     <= 1'b0;
                        mem_write <= 1'b0;
                        state_q   <= StAck;
                    end else if (wdog_q == WdLast) begin
                        data_q    <= '0;
                        err_q     <= 1'b1;
                        mem_write <= 1'b0;
                        state_q   <= StAck;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                StAck: begin
                    if (gnt_q) begin
                        p1_ack   <= 1'b1;
                        p1_rdata <= data_q;
                        p1_err   <= err_q;
                    end else begin
                        p0_ack   <= 1'b1;
                        p0_rdata <= data_q;
                        p0_err   <= err_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small delay-programmable memory responder.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [15:0] p0_addr = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_read_address, mem_write_address, mem_write_value;
    logic [15:0] mem_read_value = '0;
    logic        mem_read_ready = 1'b0, mem_write_ready = 1'b0;
    logic        busy;

    int          n_vec = 0;
    int          n_miss = 0;
    int          mem_delay = 1;   // 0 = memory never answers
    logic [15:0] mem_val = '0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_read(mem_read), .mem_read_address(mem_read_address),
        .mem_read_value(mem_read_value), .mem_read_ready(mem_read_ready),
        .mem_write(mem_write), .mem_write_address(mem_write_address),
        .mem_write_value(mem_write_value), .mem_write_ready(mem_write_ready),
        .busy(busy)
    );

    initial forever #5 clock = ~clock;

    // Memory responder: raises ready mem_delay cycles after a strobe first appears.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clock);
            mem_read_ready  = 1'b0;
            mem_write_ready = 1'b0;
            if (mem_read || mem_write) begin
                cnt++;
                if (cnt == mem_delay) begin
                    if (mem_read) begin
                        mem_read_ready = 1'b1;
                        mem_read_value = mem_val;
                    end else begin
                        mem_write_ready = 1'b1;
                    end
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running need=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Called right after a negedge; returns after the ack negedge with reqs dropped.
    task automatic txn(input int port, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, output int ack_port, output logic [15:0] rdata,
                       output logic err, output int lat, output int rd_cyc, output int wr_cyc,
                       output logic [15:0] s_addr, output logic [15:0] s_wval);
        ack_port = -1; rdata = '0; err = 1'b0; lat = 0;
        rd_cyc = 0; wr_cyc = 0; s_addr = '0; s_wval = '0;
        if (port == 0) begin
            p0_addr = addr; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        for (int i = 1; i <= 40 && ack_port < 0; i++) begin
            @(negedge clock);
            if (mem_read) begin rd_cyc++; s_addr = mem_read_address; end
            if (mem_write) begin
                wr_cyc++; s_addr = mem_write_address; s_wval = mem_write_value;
            end
            if (p0_ack) begin
                ack_port = 0; rdata = p0_rdata; err = p0_err; lat = i;
            end else if (p1_ack) begin
                ack_port = 1; rdata = p1_rdata; err = p1_err; lat = i;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    initial begin
        int          ap, lat, rc, wc, acks, left0, left1;
        logic [15:0] rd, sa, sw;
        logic        er, rr0, rr1;
        int          order[$];

        do_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        check_eq("rst_acks", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'd0);
        check_eq("rst_addr", 32'(mem_read_address), 32'd0);

        // Fetch read, memory answers after 2 cycles
        mem_delay = 2; mem_val = 16'hA5C3;
        txn(0, 1'b0, 16'h0004, 16'h0, ap, rd, er, lat, rc, wc, sa, sw);
        check_eq("rd_port", 32'(ap), 32'd0);
        check_eq("rd_data", 32'(rd), 32'hA5C3);
        check_eq("rd_err", 32'(er), 32'd0);
        check_eq("rd_addr", 32'(sa), 32'h0004);
        check_eq("rd_strobe_cyc", 32'(rc), 32'd2);
        check_eq("rd_latency", 32'(lat), 32'd4);
        @(negedge clock);
        check_eq("rd_ack_pulse", 32'({p0_ack, p1_ack}), 32'd0);

        // Data write, minimum latency
        mem_delay = 1;
        txn(1, 1'b1, 16'h0010, 16'h1234, ap, rd, er, lat, rc, wc, sa, sw);
        check_eq("wr_port", 32'(ap), 32'd1);
        check_eq("wr_err", 32'(er), 32'd0);
        check_eq("wr_addr", 32'(sa), 32'h0010);
        check_eq("wr_value", 32'(sw), 32'h1234);
        check_eq("wr_strobe_cyc", 32'(wc), 32'd1);
        check_eq("wr_no_read", 32'(rc), 32'd0);
        check_eq("wr_latency", 32'(lat), 32'd3);
        @(negedge clock);
        check_eq("wr_ack_pulse", 32'({p0_ack, p1_ack}), 32'd0);

        // Contention from reset: grants must alternate starting with port 0
        do_reset();
        mem_delay = 1; mem_val = 16'hBEEF;
        p0_addr = 16'h0030; p1_addr = 16'h0020; p1_we = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1;
        left0 = 2; left1 = 2; rr0 = 1'b0; rr1 = 1'b0;
        for (int i = 0; i < 200 && order.size() < 6; i++) begin
            @(negedge clock);
            if (rr0) begin p0_req = 1'b1; rr0 = 1'b0; end
            if (rr1) begin p1_req = 1'b1; rr1 = 1'b0; end
            if (p0_ack) begin
                order.push_back(0); p0_req = 1'b0;
                if (left0 > 0) begin left0--; rr0 = 1'b1; end
            end
            if (p1_ack) begin
                order.push_back(1); p1_req = 1'b0;
                if (left1 > 0) begin left1--; rr1 = 1'b1; end
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check_eq("rr_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < order.size(); i++)
            check_eq($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
        repeat (2) @(negedge clock);

        // Memory never answers: watchdog expires after 8 strobe cycles
        mem_delay = 0;
        txn(0, 1'b0, 16'h0040, 16'h0, ap, rd, er, lat, rc, wc, sa, sw);
        check_eq("to_port", 32'(ap), 32'd0);
        check_eq("to_err", 32'(er), 32'd1);
        check_eq("to_data", 32'(rd), 32'd0);
        check_eq("to_strobe_cyc", 32'(rc), 32'd8);
        check_eq("to_latency", 32'(lat), 32'd10);
        @(negedge clock);
        mem_delay = 1; mem_val = 16'h5A5A;
        txn(0, 1'b0, 16'h0042, 16'h0, ap, rd, er, lat, rc, wc, sa, sw);
        check_eq("after_to_data", 32'(rd), 32'h5A5A);
        check_eq("after_to_err", 32'(er), 32'd0);
        @(negedge clock);

        // Ready on the very cycle the watchdog expires
        mem_delay = 8; mem_val = 16'hC0DE;
        txn(1, 1'b0, 16'h0044, 16'h0, ap, rd, er, lat, rc, wc, sa, sw);
        check_eq("edge_port", 32'(ap), 32'd1);
        check_eq("edge_err", 32'(er), 32'd0);
        check_eq("edge_data", 32'(rd), 32'hC0DE);
        check_eq("edge_latency", 32'(lat), 32'd10);
        @(negedge clock);

        // Reset while in RD abandons the access
        mem_delay = 0;
        p0_addr = 16'h0050; p0_req = 1'b1;
        @(negedge clock);
        check_eq("mid_rd_strobe", 32'(mem_read), 32'd1);
        reset = 1'b1; p0_req = 1'b0;
        @(negedge clock);
        check_eq("mid_rst_read", 32'(mem_read), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clock);
            acks += int'(p0_ack) + int'(p1_ack);
        end
        check_eq("mid_rst_no_ack", 32'(acks), 32'd0);
        mem_delay = 1; mem_val = 16'h7777;
        txn(0, 1'b0, 16'h0052, 16'h0, ap, rd, er, lat, rc, wc, sa, sw);
        check_eq("post_rst_port", 32'(ap), 32'd0);
        check_eq("post_rst_data", 32'(rd), 32'h7777);
        check_eq("post_rst_addr", 32'(sa), 32'h0052);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
